// File: rtl/iter_shifter.sv
// Multi-cycle word shifter: SLL/SRL/SRA/ROL, up to STEP positions per clock,
// with valid/ready handshakes on request and response sides.
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// SHIFT | shifting acc by min(STEP, rem) per clock until rem reaches 0
// DONE  | result presented on resp_data until taken or aborted
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [WIDTH-1:0]           req_data,
    input  logic [$clog2(WIDTH)-1:0]   req_amt,
    input  logic [1:0]                 req_mode,
    input  logic                       abort,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [WIDTH-1:0]           resp_data,
    output logic                       busy
);

    localparam int AW = $clog2(WIDTH);
    localparam logic [AW:0] STEP_K = (AW+1)'(STEP);
    localparam logic [AW:0] WIDTH_K = (AW+1)'(WIDTH);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_ROL = 2'b10;
    localparam logic [1:0] MODE_SRA = 2'b11;

    generate
        if (STEP < 1 || STEP > WIDTH || (STEP & (STEP - 1)) != 0) begin : g_bad_step
            $fatal(1, "iter_shifter: STEP must be a power of two no larger than WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc;
    logic [AW-1:0]     rem;
    logic [1:0]        mode;
    logic              sign;

    logic              load;
    logic              step_en;
    logic [AW:0]       k;
    logic [AW:0]       k_inv;
    logic [AW-1:0]     rem_next;
    logic [WIDTH-1:0]  acc_next;

    // k never exceeds rem, so rem_next cannot wrap
    always_comb begin
        k        = ({1'b0, rem} > STEP_K) ? STEP_K : {1'b0, rem};
        k_inv    = WIDTH_K - k;
        rem_next = rem - k[AW-1:0];
        acc_next = acc;
        case (mode)
            MODE_SLL: acc_next = acc << k;
            MODE_SRL: acc_next = acc >> k;
            MODE_SRA: acc_next = (acc >> k) | (sign ? ~({WIDTH{1'b1}} >> k) : '0);
            MODE_ROL: acc_next = (acc << k) | (acc >> k_inv);
            default:  acc_next = acc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !abort) begin
                    load    = 1'b1;
                    state_d = (req_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    step_en = 1'b1;
                    if (rem_next == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (abort || resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc  <= '0;
            rem  <= '0;
            mode <= MODE_SLL;
            sign <= 1'b0;
        end else if (load) begin
            acc  <= req_data;
            rem  <= req_amt;
            mode <= req_mode;
            sign <= req_data[WIDTH-1];
        end else if (step_en) begin
            acc <= acc_next;
            rem <= rem_next;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign resp_data  = (state_q == DONE) ? acc : '0;

endmodule
